// File: rtl/spk_pkg.sv
// spk_pkg: widths, limits and FSM encoding shared by the speaker tone generator and decoder.
package spk_pkg;

  localparam int unsigned TW         = 11;
  localparam int unsigned CW         = TW + 1;
  localparam int unsigned TN_MAX     = (1 << TW) - 1;
  localparam int unsigned PERIOD_MAX = 1 << TW;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } spk_state_e;

  // Tone word from a measured period: TN = 2^TW - period (period 2^TW maps to 0)
  function automatic logic [TW-1:0] tn_from_period(input logic [CW-1:0] period);
    logic [CW-1:0] diff;
    diff = CW'(PERIOD_MAX) - period;
    return TW'(diff);
  endfunction

endpackage

// File: rtl/spk_tone_decoder_period_cnt.sv
// spk_period_cnt: cycles since the last event, plus the no-event timeout flag.
module spk_period_cnt
  import spk_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_event,
  input  logic          i_meas,
  output logic [CW-1:0] o_cnt,
  output logic          o_timeout_c
);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max    = (r_cnt == CW'(PERIOD_MAX));
  assign o_timeout_c = i_meas && !i_event && w_at_max;
  assign o_cnt       = r_cnt;

  // Event restarts the count at 1; idle or timeout parks it at 0; otherwise count up
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_event) begin
      r_cnt <= CW'(1);
    end else if (!i_meas || w_at_max) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spk_tone_decoder.sv
// spk_tone_decoder: measures the SPKS pulse period and recovers the tone word.
// Optional macro SPK_TONE_HOLD_EN: accept a measurement only when it repeats the previous period.
module spk_tone_decoder
  import spk_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_spks_in,
  output logic [TW-1:0] o_tn_out,
  output logic          o_tn_vld,
  output logic          o_tn_stb,
  output logic          o_silent
);

  spk_state_e    r_state, w_state_nxt;
  logic [TW-1:0] r_tn, w_tn_nxt;
  logic          r_vld, w_vld_nxt;
  logic          r_stb, w_stb_nxt;
  logic          r_silent, w_silent_nxt;

  logic [CW-1:0] w_cnt;
  logic          w_timeout;
  logic          w_meas;
  logic          w_accept;
  logic [TW-1:0] w_tn_calc;

  assign w_meas    = (r_state == MEAS);
  assign w_tn_calc = tn_from_period(w_cnt);

  spk_period_cnt u_period_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_event     (i_spks_in),
    .i_meas      (w_meas),
    .o_cnt       (w_cnt),
    .o_timeout_c (w_timeout)
  );

`ifdef SPK_TONE_HOLD_EN
  logic [TW-1:0] r_prev_per;
  logic          r_prev_vld;

  // Period 2^TW truncates to 0, so a separate valid bit keeps an empty history distinct
  assign w_accept = r_prev_vld && (r_prev_per == TW'(w_cnt));

  // Remember the last measured period; forget it on timeout
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev_per <= '0;
      r_prev_vld <= 1'b0;
    end else if (w_timeout) begin
      r_prev_per <= '0;
      r_prev_vld <= 1'b0;
    end else if (w_meas && i_spks_in) begin
      r_prev_per <= TW'(w_cnt);
      r_prev_vld <= 1'b1;
    end
  end
`else
  assign w_accept = 1'b1;
`endif

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_tn     <= '0;
      r_vld    <= 1'b0;
      r_stb    <= 1'b0;
      r_silent <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_tn     <= w_tn_nxt;
      r_vld    <= w_vld_nxt;
      r_stb    <= w_stb_nxt;
      r_silent <= w_silent_nxt;
    end
  end

  // Next state and next outputs; an event in MEAS always wins over timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_tn_nxt     = r_tn;
    w_vld_nxt    = r_vld;
    w_stb_nxt    = 1'b0;
    w_silent_nxt = r_silent;
    case (r_state)
      IDLE: begin
        if (i_spks_in) begin
          w_state_nxt = MEAS;
        end
      end
      MEAS: begin
        if (i_spks_in) begin
          if (w_accept) begin
            w_tn_nxt     = w_tn_calc;
            w_vld_nxt    = 1'b1;
            w_silent_nxt = 1'b0;
            w_stb_nxt    = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt  = IDLE;
          w_vld_nxt    = 1'b0;
          w_silent_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_tn_out = r_tn;
  assign o_tn_vld = r_vld;
  assign o_tn_stb = r_stb;
  assign o_silent = r_silent;

endmodule

// File: tb/tb_spk_tone_decoder.sv
// Testbench for spk_tone_decoder: pulse-train stimulus with a scoreboard of expected strobes.
module tb_spk_tone_decoder;
  import spk_pkg::*;

  typedef struct {
    logic [TW-1:0] tn;
    int unsigned   t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spks = 1'b0;
  logic [TW-1:0] tn_out;
  logic          tn_vld;
  logic          tn_stb;
  logic          silent;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  // Stimulus-side model state
  int          ev_cnt = 0;
  int unsigned last_ev = 0;
`ifdef SPK_TONE_HOLD_EN
  int unsigned prev_per = 0;
  bit          prev_vld = 1'b0;
`endif

  spk_tone_decoder dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_spks_in (spks),
    .o_tn_out  (tn_out),
    .o_tn_vld  (tn_vld),
    .o_tn_stb  (tn_stb),
    .o_silent  (silent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Record an event sampled at posedge number t and push the strobe it should cause
  function automatic void model_event(input int unsigned t);
    int unsigned gap;
    bit          acc;
    exp_t        e;
    gap = t - last_ev;
    if (ev_cnt > 0 && gap > PERIOD_MAX) begin
      ev_cnt = 0;
`ifdef SPK_TONE_HOLD_EN
      prev_vld = 1'b0;
`endif
    end
    if (ev_cnt == 0) begin
      ev_cnt = 1;
    end else begin
`ifdef SPK_TONE_HOLD_EN
      acc = prev_vld && (prev_per == gap);
      prev_per = gap;
      prev_vld = 1'b1;
`else
      acc = 1'b1;
`endif
      if (acc) begin
        e.tn = TW'(PERIOD_MAX - gap);
        e.t  = t;
        sb.push_back(e);
      end
    end
    last_ev = t;
  endfunction

  function automatic void model_reset();
    ev_cnt = 0;
`ifdef SPK_TONE_HOLD_EN
    prev_vld = 1'b0;
`endif
    sb.delete();
  endfunction

  // Scoreboard pop on every strobe: value and cycle must match the stimulus model
  always @(negedge clk) begin : mon
    exp_t e;
    if (tn_stb === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stb_unexpected: strobe with tn=%h at cyc %0d, required no strobe", tn_out, cyc);
      end else begin
        e = sb.pop_front();
        if (tn_out !== e.tn || cyc != e.t) begin
          n_fail++;
          $display("FAIL stb_value: tn=%h at cyc %0d, required tn=%h at cyc %0d", tn_out, cyc, e.tn, e.t);
        end
      end
    end
  end

  // Drive a pulse every 'period' cycles, n pulses (period 1 holds the line high)
  task automatic run_tone(input int period, input int n);
    for (int c = 0; c < period * n; c++) begin
      @(negedge clk);
      spks = ((c % period) == 0);
      if (spks) model_event(cyc + 1);
    end
  endtask

  // Release the line and require every expected strobe to have been seen
  task automatic drain(input string name);
    @(negedge clk);
    spks = 1'b0;
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_stb: %0d strobes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tn_out !== '0) begin n_fail++; $display("FAIL reset_tn: got %h required 0", tn_out); end
    n_checks++;
    if (tn_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b required 0", tn_vld); end
    n_checks++;
    if (tn_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b required 0", tn_stb); end
    n_checks++;
    if (silent !== 1'b1) begin n_fail++; $display("FAIL reset_silent: got %b required 1", silent); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock_700();
    run_tone(256, 6);
    drain("lock700");
    n_checks++;
    if (tn_out !== 11'h700) begin n_fail++; $display("FAIL lock700_tn: got %h required 700", tn_out); end
    n_checks++;
    if (tn_vld !== 1'b1) begin n_fail++; $display("FAIL lock700_vld: got %b required 1", tn_vld); end
    n_checks++;
    if (silent !== 1'b0) begin n_fail++; $display("FAIL lock700_silent: got %b required 0", silent); end
  endtask

  task automatic test_tone_change();
    run_tone(512, 3);
    drain("change600");
    n_checks++;
    if (tn_out !== 11'h600) begin n_fail++; $display("FAIL change600_tn: got %h required 600", tn_out); end
  endtask

  task automatic test_timeout();
    int unsigned t0;
    t0 = last_ev;
    while (cyc < t0 + PERIOD_MAX - 1) @(negedge clk);
    n_checks++;
    if (silent !== 1'b0 || tn_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: silent=%b vld=%b at cyc %0d, required silent=0 vld=1", silent, tn_vld, cyc);
    end
    @(negedge clk);
    n_checks++;
    if (silent !== 1'b1) begin n_fail++; $display("FAIL timeout_silent: got %b required 1", silent); end
    n_checks++;
    if (tn_vld !== 1'b0) begin n_fail++; $display("FAIL timeout_vld: got %b required 0", tn_vld); end
    n_checks++;
    if (tn_out !== 11'h600) begin n_fail++; $display("FAIL timeout_tn_kept: got %h required 600", tn_out); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_tone(1, 12);
    drain("held_high");
    n_checks++;
    if (tn_out !== 11'h7FF) begin n_fail++; $display("FAIL held_high_tn: got %h required 7ff", tn_out); end
  endtask

  task automatic test_tn_zero();
    for (int k = 0; k < 3; k++) begin
      run_tone(2048, 1);
      n_checks++;
      if (silent !== 1'b0) begin n_fail++; $display("FAIL tn_zero_silent: got %b required 0 (pass %0d)", silent, k); end
    end
    drain("tn_zero");
    n_checks++;
    if (tn_out !== 11'h000 || tn_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL tn_zero_tn: tn=%h vld=%b required tn=000 vld=1", tn_out, tn_vld);
    end
  endtask

  task automatic test_reset_mid();
    run_tone(256, 3);
    drain("pre_reset");
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (tn_out !== '0 || tn_vld !== 1'b0 || tn_stb !== 1'b0 || silent !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_outputs: tn=%h vld=%b stb=%b silent=%b required 000/0/0/1", tn_out, tn_vld, tn_stb, silent);
    end
    run_tone(256, 3);
    drain("relock");
    n_checks++;
    if (tn_out !== 11'h700 || tn_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL relock_tn: tn=%h vld=%b required tn=700 vld=1", tn_out, tn_vld);
    end
  endtask

  initial begin
    test_reset();
    test_lock_700();
    test_tone_change();
    test_timeout();
    test_back_to_back();
    test_tn_zero();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
